// File: rtl/usb_dpdm_xcvr_if.sv
// D+/D- transceiver bundle: TX packet handshake, RX bit stream and status, raw line pins.
// The transceiver connects on the slave modport; the protocol FSM or bench connects on master.
interface usb_dpdm_xcvr_if #(
    parameter int LEN_W = 7
);
    logic             tx_start;
    logic [LEN_W-1:0] tx_len;
    logic             tx_bit;
    logic             tx_bit_req;
    logic             tx_busy;
    logic             tx_done;
    logic             dp_w;
    logic             dm_w;
    logic             rx_en;
    logic             dp_r;
    logic             dm_r;
    logic             rx_bit;
    logic             rx_valid;
    logic             rx_eop;
    logic             rx_err;
    logic             rx_timeout;
    logic [LEN_W-1:0] rx_count;

    modport slave (
        input  tx_start, tx_len, tx_bit, rx_en, dp_r, dm_r,
        output tx_bit_req, tx_busy, tx_done, dp_w, dm_w,
        output rx_bit, rx_valid, rx_eop, rx_err, rx_timeout, rx_count
    );

    modport master (
        output tx_start, tx_len, tx_bit, rx_en, dp_r, dm_r,
        input  tx_bit_req, tx_busy, tx_done, dp_w, dm_w,
        input  rx_bit, rx_valid, rx_eop, rx_err, rx_timeout, rx_count
    );
endinterface

// File: rtl/usb_dpdm_xcvr.sv
// Half-duplex USB D+/D- line transceiver: serialises variable-length packets with EOP on TX,
// detects start/bits/EOP on RX with error and sync-timeout reporting.
//
// TX state | meaning                      RX state | meaning
// T_IDLE   | drive J, wait for tx_start    R_IDLE   | disabled or own TX in progress
// T_DATA   | drive tx_bit, request bits    R_SEEK   | waiting for first K, timeout runs
// T_SE0    | drive EOP SE0                 R_RECV   | delivering J/K bits
// T_JEND   | drive closing J, tx_done      R_EOP    | counting SE0, expecting J
module usb_dpdm_xcvr #(
    parameter int LEN_W   = 7,
    parameter int EOP_SE0 = 2,
    parameter int EOP_J   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_b,
    usb_dpdm_xcvr_if.slave     bus
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int SW   = $clog2(EOP_SE0 + 1);
    localparam int EMAX = (EOP_SE0 > EOP_J) ? EOP_SE0 : EOP_J;
    localparam int EW   = $clog2(EMAX + 1);
    localparam int CW   = (LEN_W > EW) ? LEN_W : EW;

    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_J   = 2'b10;

    typedef enum logic [1:0] {T_IDLE, T_DATA, T_SE0, T_JEND} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_SEEK, R_RECV, R_EOP} rx_state_t;

    tx_state_t        r_tx_state, w_tx_nxt;
    logic [CW-1:0]    r_tx_cnt, w_tx_cnt_nxt;
    logic [LEN_W-1:0] r_tx_len, w_tx_len_nxt;

    rx_state_t        r_rx_state, w_rx_nxt;
    logic [TO_W-1:0]  r_to_cnt, w_to_nxt, w_to_inc;
    logic [SW-1:0]    r_se0_cnt, w_se0_nxt;
    logic [LEN_W-1:0] r_rx_count, w_count_nxt, w_count_sat;
    logic             r_rx_bit, w_bit_nxt;
    logic             r_rx_valid, w_valid_nxt;
    logic             r_rx_eop, w_eop_nxt;
    logic             r_rx_err, w_err_nxt;
    logic             r_rx_timeout, w_timeout_nxt;
    logic [1:0]       w_line;
    logic             w_rx_hold;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_tx_state <= T_IDLE;
            r_tx_cnt   <= '0;
            r_tx_len   <= '0;
        end else begin
            r_tx_state <= w_tx_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_len   <= w_tx_len_nxt;
        end
    end

    always_comb begin
        w_tx_nxt     = r_tx_state;
        w_tx_cnt_nxt = r_tx_cnt;
        w_tx_len_nxt = r_tx_len;
        case (r_tx_state)
            T_IDLE: begin
                if (bus.tx_start && (bus.tx_len != '0)) begin
                    w_tx_nxt     = T_DATA;
                    w_tx_cnt_nxt = '0;
                    w_tx_len_nxt = bus.tx_len;
                end
            end
            T_DATA: begin
                if (r_tx_cnt == (CW'(r_tx_len) - CW'(1))) begin
                    w_tx_nxt     = T_SE0;
                    w_tx_cnt_nxt = '0;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + CW'(1);
                end
            end
            T_SE0: begin
                if (r_tx_cnt == CW'(EOP_SE0 - 1)) begin
                    w_tx_nxt     = T_JEND;
                    w_tx_cnt_nxt = '0;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + CW'(1);
                end
            end
            T_JEND: begin
                if (r_tx_cnt == CW'(EOP_J - 1)) begin
                    w_tx_nxt     = T_IDLE;
                    w_tx_cnt_nxt = '0;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + CW'(1);
                end
            end
            default: begin
                w_tx_nxt     = T_IDLE;
                w_tx_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        bus.dp_w       = 1'b1;
        bus.dm_w       = 1'b0;
        bus.tx_bit_req = 1'b0;
        bus.tx_done    = 1'b0;
        bus.tx_busy    = (r_tx_state != T_IDLE);
        case (r_tx_state)
            T_DATA: begin
                bus.dp_w       = bus.tx_bit;
                bus.dm_w       = ~bus.tx_bit;
                bus.tx_bit_req = 1'b1;
            end
            T_SE0: begin
                bus.dp_w = 1'b0;
                bus.dm_w = 1'b0;
            end
            T_JEND: bus.tx_done = (r_tx_cnt == CW'(EOP_J - 1));
            default: ;
        endcase
    end

    // Receiver is parked whenever we are driving the line ourselves.
    assign w_rx_hold   = !bus.rx_en || bus.tx_busy;
    assign w_line      = {bus.dp_r, bus.dm_r};
    assign w_to_inc    = r_to_cnt + TO_W'(1);
    assign w_count_sat = (r_rx_count == '1) ? r_rx_count : r_rx_count + LEN_W'(1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rx_state   <= R_IDLE;
            r_to_cnt     <= '0;
            r_se0_cnt    <= '0;
            r_rx_count   <= '0;
            r_rx_bit     <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_eop     <= 1'b0;
            r_rx_err     <= 1'b0;
            r_rx_timeout <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_nxt;
            r_to_cnt     <= w_to_nxt;
            r_se0_cnt    <= w_se0_nxt;
            r_rx_count   <= w_count_nxt;
            r_rx_bit     <= w_bit_nxt;
            r_rx_valid   <= w_valid_nxt;
            r_rx_eop     <= w_eop_nxt;
            r_rx_err     <= w_err_nxt;
            r_rx_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_rx_nxt      = r_rx_state;
        w_to_nxt      = r_to_cnt;
        w_se0_nxt     = r_se0_cnt;
        w_count_nxt   = r_rx_count;
        w_bit_nxt     = r_rx_bit;
        w_valid_nxt   = 1'b0;
        w_eop_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_timeout_nxt = 1'b0;
        if (w_rx_hold) begin
            w_rx_nxt = R_IDLE;
            w_to_nxt = '0;
        end else begin
            case (r_rx_state)
                R_IDLE: begin
                    w_rx_nxt = R_SEEK;
                    w_to_nxt = '0;
                end
                R_SEEK: begin
                    if (w_line == LINE_K) begin
                        w_rx_nxt    = R_RECV;
                        w_valid_nxt = 1'b1;
                        w_bit_nxt   = bus.dp_r;
                        w_count_nxt = LEN_W'(1);
                        w_to_nxt    = '0;
                    end else if (w_to_inc == TO_W'(TIMEOUT)) begin
                        w_timeout_nxt = 1'b1;
                        w_to_nxt      = '0;
                    end else begin
                        w_to_nxt = w_to_inc;
                    end
                end
                R_RECV: begin
                    case (w_line)
                        LINE_J, LINE_K: begin
                            w_valid_nxt = 1'b1;
                            w_bit_nxt   = bus.dp_r;
                            w_count_nxt = w_count_sat;
                        end
                        LINE_SE0: begin
                            w_rx_nxt  = R_EOP;
                            w_se0_nxt = SW'(1);
                        end
                        default: begin
                            w_rx_nxt  = R_SEEK;
                            w_err_nxt = 1'b1;
                        end
                    endcase
                end
                R_EOP: begin
                    if (w_line == LINE_SE0) begin
                        w_se0_nxt = (r_se0_cnt == '1) ? r_se0_cnt : r_se0_cnt + SW'(1);
                    end else begin
                        w_rx_nxt = R_SEEK;
                        if ((w_line == LINE_J) && (r_se0_cnt >= SW'(EOP_SE0))) begin
                            w_eop_nxt = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                default: w_rx_nxt = R_IDLE;
            endcase
        end
    end

    assign bus.rx_bit     = r_rx_bit;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.rx_eop     = r_rx_eop;
    assign bus.rx_err     = r_rx_err;
    assign bus.rx_timeout = r_rx_timeout;
    assign bus.rx_count   = r_rx_count;
endmodule

// File: tb/tb_usb_dpdm_xcvr.sv
// Bench for usb_dpdm_xcvr: directed and randomized TX packets and RX line sequences,
// expectations built from packet descriptions; a LEN_W=4 instance covers count saturation.
module tb_usb_dpdm_xcvr;
    localparam int EOP_SE0 = 2;
    localparam int EOP_J   = 1;
    localparam int TIMEOUT = 255;
    localparam logic [1:0] SJ   = 2'b10;
    localparam logic [1:0] SK   = 2'b01;
    localparam logic [1:0] SSE0 = 2'b00;
    localparam logic [1:0] SSE1 = 2'b11;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    usb_dpdm_xcvr_if #(.LEN_W(7)) bus ();
    usb_dpdm_xcvr_if #(.LEN_W(4)) bus4 ();

    usb_dpdm_xcvr #(.LEN_W(7), .EOP_SE0(EOP_SE0), .EOP_J(EOP_J), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst_b(rst_b), .bus(bus)
    );
    usb_dpdm_xcvr #(.LEN_W(4), .EOP_SE0(EOP_SE0), .EOP_J(EOP_J), .TIMEOUT(TIMEOUT)) u_dut4 (
        .clk(clk), .rst_b(rst_b), .bus(bus4)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_line(input logic [1:0] s);
        bus.dp_r  = s[1];
        bus.dm_r  = s[0];
        bus4.dp_r = s[1];
        bus4.dm_r = s[0];
    endtask

    // One TX packet of len bits taken LSB-first from pat; poke asserts tx_start during busy.
    task automatic tx_packet(input int len, input logic [127:0] pat, input bit poke);
        int last;
        last = len + EOP_SE0 + EOP_J;
        bus.tx_len   = 7'(len);
        bus.tx_start = 1'b1;
        step();
        for (int k = 1; k <= last; k++) begin
            bus.tx_start = poke;
            bus.tx_len   = 7'($urandom);
            bus.tx_bit   = (k <= len) ? pat[k-1] : 1'($urandom);
            #1;
            chk1("tx_busy", bus.tx_busy, 1'b1);
            chk1("tx_no_rx_valid", bus.rx_valid, 1'b0);
            if (k <= len) begin
                chk1("tx_req_data", bus.tx_bit_req, 1'b1);
                chk1("tx_dp_data", bus.dp_w, pat[k-1]);
                chk1("tx_dm_data", bus.dm_w, ~pat[k-1]);
                chk1("tx_done_data", bus.tx_done, 1'b0);
            end else if (k <= len + EOP_SE0) begin
                chk1("tx_req_se0", bus.tx_bit_req, 1'b0);
                chk1("tx_dp_se0", bus.dp_w, 1'b0);
                chk1("tx_dm_se0", bus.dm_w, 1'b0);
                chk1("tx_done_se0", bus.tx_done, 1'b0);
            end else begin
                chk1("tx_req_j", bus.tx_bit_req, 1'b0);
                chk1("tx_dp_j", bus.dp_w, 1'b1);
                chk1("tx_dm_j", bus.dm_w, 1'b0);
                chk1("tx_done_j", bus.tx_done, k == last);
            end
            step();
        end
        bus.tx_start = 1'b0;
        #1;
        chk1("tx_idle_busy", bus.tx_busy, 1'b0);
        chk1("tx_idle_done", bus.tx_done, 1'b0);
        chk1("tx_idle_dp", bus.dp_w, 1'b1);
        chk1("tx_idle_dm", bus.dm_w, 1'b0);
    endtask

    task automatic chk_rx(input string tag, input logic v, input logic b, input logic e,
                          input logic er, input int c7, input int c4);
        chk1({tag, ".valid"}, bus.rx_valid, v);
        chk1({tag, ".eop"}, bus.rx_eop, e);
        chk1({tag, ".err"}, bus.rx_err, er);
        chk1({tag, ".timeout"}, bus.rx_timeout, 1'b0);
        chkn({tag, ".count"}, int'(bus.rx_count), c7);
        chk1({tag, ".valid4"}, bus4.rx_valid, v);
        chk1({tag, ".eop4"}, bus4.rx_eop, e);
        chk1({tag, ".err4"}, bus4.rx_err, er);
        chkn({tag, ".count4"}, int'(bus4.rx_count), c4);
        if (v) begin
            chk1({tag, ".bit"}, bus.rx_bit, b);
            chk1({tag, ".bit4"}, bus4.rx_bit, b);
        end
    endtask

    // Packet: nb bits (bit 0 must be 0 = K), nse0 SE0 symbols, terminator symbol, gap of J.
    task automatic rx_packet(input int nb, input logic [63:0] bits, input int nse0,
                             input logic [1:0] term, input int gap);
        logic ok_eop;
        int   h7, h4;
        for (int i = 0; i < nb; i++) begin
            set_line(bits[i] ? SJ : SK);
            step();
            chk_rx("rx_bit", 1'b1, bits[i], 1'b0, 1'b0, imin(i + 1, 127), imin(i + 1, 15));
        end
        h7 = imin(nb, 127);
        h4 = imin(nb, 15);
        for (int j = 0; j < nse0; j++) begin
            set_line(SSE0);
            step();
            chk_rx("rx_se0", 1'b0, 1'b0, 1'b0, 1'b0, h7, h4);
        end
        ok_eop = (term == SJ) && (nse0 >= EOP_SE0);
        set_line(term);
        step();
        chk_rx("rx_term", 1'b0, 1'b0, ok_eop, !ok_eop, h7, h4);
        for (int g = 0; g < gap; g++) begin
            set_line(SJ);
            step();
            chk_rx("rx_gap", 1'b0, 1'b0, 1'b0, 1'b0, h7, h4);
        end
    endtask

    initial begin
        logic [63:0]  b;
        logic [1:0]   term;
        int           nse0;
        int           t;
        bus.tx_start  = 1'b0;
        bus.tx_len    = '0;
        bus.tx_bit    = 1'b0;
        bus.rx_en     = 1'b0;
        bus4.tx_start = 1'b0;
        bus4.tx_len   = '0;
        bus4.tx_bit   = 1'b0;
        bus4.rx_en    = 1'b0;
        set_line(SJ);
        #12;
        chk1("rst_dp", bus.dp_w, 1'b1);
        chk1("rst_dm", bus.dm_w, 1'b0);
        chk1("rst_req", bus.tx_bit_req, 1'b0);
        chk1("rst_busy", bus.tx_busy, 1'b0);
        chk1("rst_done", bus.tx_done, 1'b0);
        chk1("rst_rx_bit", bus.rx_bit, 1'b0);
        chk1("rst_valid", bus.rx_valid, 1'b0);
        chk1("rst_eop", bus.rx_eop, 1'b0);
        chk1("rst_err", bus.rx_err, 1'b0);
        chk1("rst_timeout", bus.rx_timeout, 1'b0);
        chkn("rst_count", int'(bus.rx_count), 0);
        chkn("rst_count4", int'(bus4.rx_count), 0);
        rst_b = 1'b1;
        step();

        // zero length is ignored
        bus.tx_start = 1'b1;
        bus.tx_len   = '0;
        step();
        bus.tx_start = 1'b0;
        chk1("len0_busy", bus.tx_busy, 1'b0);
        chk1("len0_dp", bus.dp_w, 1'b1);

        // reset in cycle 5 of a 32-bit packet
        bus.tx_start = 1'b1;
        bus.tx_len   = 7'd32;
        step();
        bus.tx_start = 1'b0;
        repeat (4) step();
        chk1("mid_busy", bus.tx_busy, 1'b1);
        rst_b = 1'b0;
        #1;
        chk1("mid_rst_dp", bus.dp_w, 1'b1);
        chk1("mid_rst_dm", bus.dm_w, 1'b0);
        chk1("mid_rst_busy", bus.tx_busy, 1'b0);
        chk1("mid_rst_done", bus.tx_done, 1'b0);
        step();
        rst_b = 1'b1;
        step();
        chk1("post_rst_busy", bus.tx_busy, 1'b0);
        chk1("post_rst_dp", bus.dp_w, 1'b1);
        chk1("post_rst_done", bus.tx_done, 1'b0);

        // TX packets; RX enabled with K on the line must stay silent while busy
        set_line(SK);
        bus.rx_en = 1'b1;
        tx_packet(12, 128'h5A3, 1'b1);
        for (int n = 0; n < 6; n++) begin
            tx_packet(int'($urandom_range(1, 40)), {$urandom, $urandom, $urandom, $urandom},
                      1'($urandom));
        end
        bus.rx_en = 1'b0;
        set_line(SJ);
        step();

        // RX
        bus.rx_en  = 1'b1;
        bus4.rx_en = 1'b1;
        step();
        b = '0;
        b[7:0]  = 8'h2A;
        b[31:8] = 24'($urandom);
        rx_packet(32, b, 2, SJ, 3);
        b = {$urandom, $urandom};
        b[0] = 1'b0;
        rx_packet(10, b, 1, SJ, 2);
        b = {$urandom, $urandom};
        b[0] = 1'b0;
        rx_packet(6, b, 0, SSE1, 0);
        b = {$urandom, $urandom};
        b[0] = 1'b0;
        rx_packet(5, b, 2, SJ, 1);
        b = {$urandom, $urandom};
        b[0] = 1'b0;
        rx_packet(20, b, 2, SJ, 2);
        for (int n = 0; n < 10; n++) begin
            b = {$urandom, $urandom};
            b[0] = 1'b0;
            nse0 = int'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1:    term = SJ;
                2:       term = SK;
                default: term = SSE1;
            endcase
            if (nse0 == 0) term = SSE1;
            rx_packet(int'($urandom_range(1, 40)), b, nse0, term, int'($urandom_range(0, 4)));
        end

        // sync timeout on an idle J line
        bus.rx_en  = 1'b0;
        bus4.rx_en = 1'b0;
        set_line(SJ);
        step();
        bus.rx_en = 1'b1;
        t = 0;
        step();
        while (!bus.rx_timeout && t < 300) begin
            step();
            t++;
        end
        chk1("to_first", bus.rx_timeout, 1'b1);
        for (int n = 0; n < 2; n++) begin
            t = 0;
            do begin
                step();
                t++;
                if (bus.rx_timeout === 1'b0 && (bus.rx_valid | bus.rx_eop | bus.rx_err) !== 1'b0) begin
                    chk1("to_quiet", 1'b1, 1'b0);
                end
            end while (!bus.rx_timeout && t < 300);
            chkn("to_interval", t, TIMEOUT);
        end
        bus.rx_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
